// File: rtl/sc_turn_arbiter.sv
// sc_turn_arbiter: two-player turn scheduler for the shared playfield shift
// register. Grants one boundary-checked move per turn, alternating P1/P2,
// forfeits a turn after TIMEOUT_CYCLES idle cycles and ends the game once a
// player has missed MAX_MISSES turns since the last clear.
//
// Handshake: a move request is a level on the owner's 2-bit code. It is
// accepted (consumed) only in TURN when the code is 01/10 and the matching
// limit input is high. After acceptance the owner must return to 11 before
// the turn passes, so one press yields exactly one move.
//
// Debug: SC_TURNARBITER_state_Out exposes the registered FSM state
// (0 IDLE, 1 CLEAR, 2 TURN, 3 MOVE, 4 RELEASE, 5 PASS, 6 OVER).
module sc_turn_arbiter #(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int TIMEOUT_W      = 26,
   parameter int MAX_MISSES     = 3,
   parameter int MISS_W         = 2,
   parameter int MOVE_W         = 8
) (
   input  logic              SC_TURNARBITER_CLOCK_50,
   input  logic              SC_TURNARBITER_RESET_InHigh,
   input  logic              SC_TURNARBITER_startButton_InLow,
   input  logic [1:0]        SC_TURNARBITER_p1Request_In,
   input  logic [1:0]        SC_TURNARBITER_p2Request_In,
   input  logic              SC_TURNARBITER_leftLimit_InLow,
   input  logic              SC_TURNARBITER_rightLimit_InLow,
   output logic              SC_TURNARBITER_clear_OutLow,
   output logic [1:0]        SC_TURNARBITER_shiftselection_Out,
   output logic              SC_TURNARBITER_turn_Out,
   output logic              SC_TURNARBITER_grant1_Out,
   output logic              SC_TURNARBITER_grant2_Out,
   output logic              SC_TURNARBITER_timeout_Out,
   output logic              SC_TURNARBITER_gameover_Out,
   output logic              SC_TURNARBITER_winner_Out,
   output logic [MOVE_W-1:0] SC_TURNARBITER_movecount_Out,
   output logic [2:0]        SC_TURNARBITER_state_Out
);

   typedef enum logic [2:0] {
      STATE_IDLE    = 3'd0,
      STATE_CLEAR   = 3'd1,
      STATE_TURN    = 3'd2,
      STATE_MOVE    = 3'd3,
      STATE_RELEASE = 3'd4,
      STATE_PASS    = 3'd5,
      STATE_OVER    = 3'd6
   } state_t;

   localparam logic [1:0] CODE_IDLE  = 2'b11;
   localparam logic [1:0] CODE_LEFT  = 2'b01;
   localparam logic [1:0] CODE_RIGHT = 2'b10;

   state_t               state;
   state_t               stateNext;
   logic                 turn;
   logic [TIMEOUT_W-1:0] timer;
   logic [MISS_W-1:0]    miss1;
   logic [MISS_W-1:0]    miss2;
   logic [MOVE_W-1:0]    moveCount;
   logic                 winner;
   logic [1:0]           moveCode;

   logic [1:0]           ownerReq;
   logic                 validReq;
   logic                 timerDone;
   logic [MISS_W-1:0]    ownerMiss;
   logic [MISS_W-1:0]    missInc;
   logic                 missLimit;

   // Request selection (the only Mealy path) and turn bookkeeping terms
   always_comb begin
      ownerReq  = turn ? SC_TURNARBITER_p2Request_In : SC_TURNARBITER_p1Request_In;
      validReq  = ((ownerReq == CODE_LEFT)  && SC_TURNARBITER_leftLimit_InLow) ||
                  ((ownerReq == CODE_RIGHT) && SC_TURNARBITER_rightLimit_InLow);
      timerDone = (timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
      ownerMiss = turn ? miss2 : miss1;
      missInc   = ownerMiss + MISS_W'(1);
      missLimit = (missInc == MISS_W'(MAX_MISSES));
   end

   // State register; reset overrides every transition
   always_ff @(posedge SC_TURNARBITER_CLOCK_50) begin
      if (SC_TURNARBITER_RESET_InHigh) begin
         state <= STATE_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; unused encodings fall back to IDLE
   always_comb begin
      stateNext = state;
      case (state)
         STATE_IDLE:    if (!SC_TURNARBITER_startButton_InLow) stateNext = STATE_CLEAR;
         STATE_CLEAR:   stateNext = STATE_TURN;
         STATE_TURN: begin
            if (validReq) begin
               stateNext = STATE_MOVE;
            end else if (timerDone) begin
               stateNext = STATE_PASS;
            end
         end
         STATE_MOVE:    stateNext = STATE_RELEASE;
         STATE_RELEASE: if (ownerReq == CODE_IDLE) stateNext = STATE_TURN;
         STATE_PASS:    stateNext = missLimit ? STATE_OVER : STATE_TURN;
         STATE_OVER:    if (!SC_TURNARBITER_startButton_InLow) stateNext = STATE_CLEAR;
         default:       stateNext = STATE_IDLE;
      endcase
   end

   // Turn owner, timer, miss/move counters, latched move code and winner
   always_ff @(posedge SC_TURNARBITER_CLOCK_50) begin
      if (SC_TURNARBITER_RESET_InHigh) begin
         turn      <= 1'b0;
         timer     <= '0;
         miss1     <= '0;
         miss2     <= '0;
         moveCount <= '0;
         winner    <= 1'b0;
         moveCode  <= CODE_IDLE;
      end else begin
         case (state)
            STATE_CLEAR: begin
               turn      <= 1'b0;
               timer     <= '0;
               miss1     <= '0;
               miss2     <= '0;
               moveCount <= '0;
            end
            STATE_TURN: begin
               if (validReq) begin
                  moveCode <= ownerReq;
                  timer    <= '0;
               end else if (timerDone) begin
                  timer <= '0;
               end else begin
                  timer <= timer + TIMEOUT_W'(1);
               end
            end
            STATE_MOVE: begin
               if (moveCount != {MOVE_W{1'b1}}) begin
                  moveCount <= moveCount + MOVE_W'(1);
               end
            end
            STATE_RELEASE: begin
               if (ownerReq == CODE_IDLE) begin
                  turn  <= ~turn;
                  timer <= '0;
               end
            end
            STATE_PASS: begin
               if (turn) begin
                  miss2 <= missInc;
               end else begin
                  miss1 <= missInc;
               end
               if (missLimit) begin
                  winner <= ~turn;
               end else begin
                  turn  <= ~turn;
                  timer <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Moore outputs decoded from the registered state
   always_comb begin
      SC_TURNARBITER_clear_OutLow       = (state != STATE_CLEAR);
      SC_TURNARBITER_shiftselection_Out = (state == STATE_MOVE) ? moveCode : CODE_IDLE;
      SC_TURNARBITER_grant1_Out         = (state == STATE_MOVE) && !turn;
      SC_TURNARBITER_grant2_Out         = (state == STATE_MOVE) && turn;
      SC_TURNARBITER_timeout_Out        = (state == STATE_PASS);
      SC_TURNARBITER_gameover_Out       = (state == STATE_OVER);
      SC_TURNARBITER_turn_Out           = turn;
      SC_TURNARBITER_winner_Out         = winner;
      SC_TURNARBITER_movecount_Out      = moveCount;
      SC_TURNARBITER_state_Out          = state;
   end

endmodule

// File: tb/tb_sc_turn_arbiter.sv
// tb_sc_turn_arbiter: directed bench for sc_turn_arbiter with a short timeout.
module tb_sc_turn_arbiter;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int TIMEOUT_W      = 4;
  localparam int MAX_MISSES     = 3;
  localparam int MISS_W         = 2;
  localparam int MOVE_W         = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_TURN    = 3'd2;
  localparam logic [2:0] S_MOVE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_PASS    = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;

  logic              clk;
  logic              rst;
  logic              start_n;
  logic [1:0]        p1_req;
  logic [1:0]        p2_req;
  logic              left_lim;
  logic              right_lim;
  logic              clear_n;
  logic [1:0]        shift_sel;
  logic              turn;
  logic              grant1;
  logic              grant2;
  logic              timeout;
  logic              gameover;
  logic              winner;
  logic [MOVE_W-1:0] movecount;
  logic [2:0]        state;

  int checks_cnt;
  int fail_cnt;

  // expected move observations: {grant2, grant1, shiftselection}
  logic [3:0] exp_q[$];

  sc_turn_arbiter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W(TIMEOUT_W),
    .MAX_MISSES(MAX_MISSES),
    .MISS_W(MISS_W),
    .MOVE_W(MOVE_W)
  ) dut (
    .SC_TURNARBITER_CLOCK_50(clk),
    .SC_TURNARBITER_RESET_InHigh(rst),
    .SC_TURNARBITER_startButton_InLow(start_n),
    .SC_TURNARBITER_p1Request_In(p1_req),
    .SC_TURNARBITER_p2Request_In(p2_req),
    .SC_TURNARBITER_leftLimit_InLow(left_lim),
    .SC_TURNARBITER_rightLimit_InLow(right_lim),
    .SC_TURNARBITER_clear_OutLow(clear_n),
    .SC_TURNARBITER_shiftselection_Out(shift_sel),
    .SC_TURNARBITER_turn_Out(turn),
    .SC_TURNARBITER_grant1_Out(grant1),
    .SC_TURNARBITER_grant2_Out(grant2),
    .SC_TURNARBITER_timeout_Out(timeout),
    .SC_TURNARBITER_gameover_Out(gameover),
    .SC_TURNARBITER_winner_Out(winner),
    .SC_TURNARBITER_movecount_Out(movecount),
    .SC_TURNARBITER_state_Out(state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // scoreboard: every grant/shift cycle must match the next expected move
  always @(negedge clk) begin
    logic [3:0] obs;
    obs = {grant2, grant1, shift_sel};
    if (obs !== 4'b0011 && !$isunknown(obs)) begin
      if (exp_q.size() == 0) check_val("unexpected_move", 32'(obs), 32'h3);
      else check_val("move", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  // reset + start sequence ending in TURN with P1 owning the turn
  task automatic restart_game();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_n = 1'b0;
    tick();
    check_val("restart_clear", 32'(clear_n), 32'h0);
    start_n = 1'b1;
    tick();
  endtask

  // one full owner move: request, grant, release to idle
  task automatic do_move(input logic p2, input logic [1:0] code);
    exp_q.push_back({p2, ~p2, code});
    if (p2) p2_req = code; else p1_req = code;
    tick();
    tick();
    if (p2) p2_req = 2'b11; else p1_req = 2'b11;
    tick();
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    start_n    = 1'b1;
    p1_req     = 2'b11;
    p2_req     = 2'b11;
    left_lim   = 1'b1;
    right_lim  = 1'b1;

    // reset held 2 cycles
    tick_n(2);
    check_val("rst_state", 32'(state), 32'(S_IDLE));
    check_val("rst_clear", 32'(clear_n), 32'h1);
    check_val("rst_shift", 32'(shift_sel), 32'h3);
    check_val("rst_turn", 32'(turn), 32'h0);
    check_val("rst_gameover", 32'(gameover), 32'h0);
    check_val("rst_timeout", 32'(timeout), 32'h0);
    check_val("rst_movecount", 32'(movecount), 32'h0);
    check_val("rst_winner", 32'(winner), 32'h0);
    rst = 1'b0;
    tick();
    check_val("idle_wait", 32'(state), 32'(S_IDLE));

    // start pulse -> exactly one clear cycle
    start_n = 1'b0;
    tick();
    check_val("clear_low", 32'(clear_n), 32'h0);
    start_n = 1'b1;
    tick();
    check_val("clear_done", 32'(clear_n), 32'h1);
    check_val("turn_after_clear", 32'(turn), 32'h0);
    check_val("shift_after_clear", 32'(shift_sel), 32'h3);
    check_val("state_turn", 32'(state), 32'(S_TURN));

    // P1 left move, one cycle latency
    exp_q.push_back(4'b0101);
    p1_req = 2'b01;
    tick();
    check_val("p1_move_state", 32'(state), 32'(S_MOVE));
    check_val("p1_shift_left", 32'(shift_sel), 32'h1);
    check_val("p1_grant1", 32'(grant1), 32'h1);
    tick();
    check_val("p1_grant1_pulse", 32'(grant1), 32'h0);
    check_val("p1_release_state", 32'(state), 32'(S_RELEASE));
    p1_req = 2'b11;
    tick();
    check_val("turn_to_p2", 32'(turn), 32'h1);
    check_val("movecount_1", 32'(movecount), 32'h1);

    // P2 right move, then P1 holds left 20 cycles while P2 also requests
    do_move(1'b1, 2'b10);
    check_val("turn_back_p1", 32'(turn), 32'h0);
    exp_q.push_back(4'b0101);
    p1_req = 2'b01;
    p2_req = 2'b10;
    tick_n(20);
    check_val("hold_state", 32'(state), 32'(S_RELEASE));
    check_val("hold_turn", 32'(turn), 32'h0);
    check_val("hold_movecount", 32'(movecount), 32'h3);
    p1_req = 2'b11;
    p2_req = 2'b11;
    tick();
    check_val("turn_p2_again", 32'(turn), 32'h1);

    // P2 blocked at right edge -> timeout after 8 TURN cycles
    right_lim = 1'b0;
    p2_req = 2'b10;
    tick_n(7);
    check_val("blocked_still_turn", 32'(state), 32'(S_TURN));
    check_val("blocked_no_timeout", 32'(timeout), 32'h0);
    tick();
    check_val("timeout_pulse", 32'(timeout), 32'h1);
    tick();
    check_val("timeout_pulse_end", 32'(timeout), 32'h0);
    check_val("turn_after_timeout", 32'(turn), 32'h0);
    right_lim = 1'b1;
    p2_req = 2'b11;

    // P1 blocked at left edge until the timeout cycle: valid request wins
    left_lim = 1'b0;
    p1_req = 2'b01;
    tick_n(7);
    exp_q.push_back(4'b0101);
    left_lim = 1'b1;
    tick();
    check_val("race_move_wins", 32'(state), 32'(S_MOVE));
    check_val("race_no_timeout", 32'(timeout), 32'h0);
    tick();
    p1_req = 2'b11;
    tick();
    check_val("race_movecount", 32'(movecount), 32'h4);
    check_val("race_turn_p2", 32'(turn), 32'h1);

    // fresh game: P2 idles 3 turns -> P1 wins
    restart_game();
    check_val("new_game_movecount", 32'(movecount), 32'h0);
    for (int r = 0; r < 3; r++) begin
      do_move(1'b0, 2'b10);
      check_val("idle_round_turn", 32'(turn), 32'h1);
      if (r == 0) start_n = 1'b0;
      tick_n(8);
      start_n = 1'b1;
      check_val("idle_round_timeout", 32'(timeout), 32'h1);
      tick();
      if (r < 2) check_val("idle_round_back_p1", 32'(turn), 32'h0);
    end
    check_val("over_gameover", 32'(gameover), 32'h1);
    check_val("over_winner", 32'(winner), 32'h0);
    check_val("over_state", 32'(state), 32'(S_OVER));
    check_val("over_movecount", 32'(movecount), 32'h3);
    tick_n(3);
    check_val("over_held", 32'(gameover), 32'h1);
    start_n = 1'b0;
    tick();
    check_val("over_restart_clear", 32'(clear_n), 32'h0);
    start_n = 1'b1;
    tick();
    check_val("over_restart_movecount", 32'(movecount), 32'h0);
    check_val("over_restart_gameover", 32'(gameover), 32'h0);
    check_val("over_restart_turn", 32'(turn), 32'h0);

    // reset asserted during MOVE
    do_move(1'b0, 2'b01);
    exp_q.push_back(4'b1001);
    p2_req = 2'b01;
    tick();
    check_val("mid_move_state", 32'(state), 32'(S_MOVE));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p2_req = 2'b11;
    check_val("mid_rst_state", 32'(state), 32'(S_IDLE));
    check_val("mid_rst_shift", 32'(shift_sel), 32'h3);
    check_val("mid_rst_grant2", 32'(grant2), 32'h0);
    check_val("mid_rst_clear", 32'(clear_n), 32'h1);
    check_val("mid_rst_turn", 32'(turn), 32'h0);
    check_val("mid_rst_movecount", 32'(movecount), 32'h0);
    tick_n(2);
    check_val("mid_rst_stays_idle", 32'(state), 32'(S_IDLE));

    check_val("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
